// File: rtl/fabric_bitstream_loader.sv
// rtl/fabric_bitstream_loader.sv - sync/header/data parser that writes configuration frames into the fabric
// Optional end-of-session checksum word enabled by FABRIC_LOADER_CHECKSUM_EN.
module fabric_bitstream_loader #(
    parameter int          NUM_ROWS       = 16,
    parameter int          NUM_COLUMNS    = 16,
    parameter int          FRAMES_PER_COL = 20,
    parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [31:0]                         bitstream_data_i,
    input  logic                                bitstream_valid_i,
    output logic [NUM_ROWS*32-1:0]              frame_data_o,
    output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] frame_strobe_o,
    output logic                                config_busy_o,
    output logic                                config_done_o,
    output logic                                error_o
);
    localparam int FW = NUM_ROWS * 32;
    localparam int NS = NUM_COLUMNS * FRAMES_PER_COL;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_DESYNC = 4'hD;

`ifdef FABRIC_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK} state_t;
    logic [31:0] sum_q, sum_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;
`endif

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [FW-1:0]   buf_q, buf_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [7:0]      col_q, col_d;
    logic [4:0]      frm_q, frm_d;
    logic            ok_q, ok_d;
    logic            pend_q, pend_d;
    logic [NS-1:0]   strobe_q, strobe_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [FW-1:0]   shift_w;
    logic [31:0]     tgt_idx;
    logic            in_range;

    if (NUM_ROWS > 1) begin : g_shift
        assign shift_w = {buf_q[FW-33:0], bitstream_data_i};
    end else begin : g_single
        assign shift_w = bitstream_data_i;
    end

    assign tgt_idx  = 32'(col_q) * 32'(FRAMES_PER_COL) + 32'(frm_q);
    assign in_range = ({24'd0, bitstream_data_i[23:16]} < 32'(NUM_COLUMNS)) &&
                      ({27'd0, bitstream_data_i[4:0]}   < 32'(FRAMES_PER_COL));

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        buf_d    = buf_q;
        frame_d  = frame_q;
        col_d    = col_q;
        frm_d    = frm_q;
        ok_d     = ok_q;
        pend_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;
        // Target registers only change on a header, which is at least one
        // cycle after pend_q is set, so this still sees the finished frame.
        strobe_d = pend_q ? (NS'(1) << tgt_idx) : '0;
`ifdef FABRIC_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        if (bitstream_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (bitstream_data_i == SYNC_WORD) begin
                        state_d = S_HEADER;
                        err_d   = 1'b0;
`ifdef FABRIC_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                S_HEADER: begin
                    case (bitstream_data_i[31:28])
                        OP_WRITE: begin
                            state_d = S_DATA;
                            row_d   = '0;
                            col_d   = bitstream_data_i[23:16];
                            frm_d   = bitstream_data_i[4:0];
                            ok_d    = in_range;
                            if (!in_range) err_d = 1'b1;
                        end
                        OP_DESYNC: begin
`ifdef FABRIC_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                        default: begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
                S_DATA: begin
                    buf_d = shift_w;
`ifdef FABRIC_LOADER_CHECKSUM_EN
                    sum_d = sum_q + bitstream_data_i;
`endif
                    if (row_q == RW'(NUM_ROWS - 1)) begin
                        frame_d = shift_w;
                        pend_d  = ok_q;
                        state_d = S_HEADER;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
`ifdef FABRIC_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    state_d = S_IDLE;
                    if (bitstream_data_i == sum_q) done_d = 1'b1;
                    else                           err_d  = 1'b1;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            buf_q    <= '0;
            frame_q  <= '0;
            col_q    <= '0;
            frm_q    <= '0;
            ok_q     <= 1'b0;
            pend_q   <= 1'b0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef FABRIC_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            buf_q    <= buf_d;
            frame_q  <= frame_d;
            col_q    <= col_d;
            frm_q    <= frm_d;
            ok_q     <= ok_d;
            pend_q   <= pend_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef FABRIC_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign frame_data_o   = frame_q;
    assign frame_strobe_o = strobe_q;
    assign config_busy_o  = (state_q != S_IDLE);
    assign config_done_o  = done_q;
    assign error_o        = err_q;
endmodule

// File: tb/tb_fabric_bitstream_loader.sv
// tb/tb_fabric_bitstream_loader.sv - scoreboard bench for fabric_bitstream_loader
module tb_fabric_bitstream_loader;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  data = '0;
    logic         valid = 1'b0;
    logic [127:0] frame_data;
    logic [7:0]   strobe;
    logic         busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] msum = '0;

    typedef struct {
        logic [7:0]   strobe;
        logic [127:0] frame;
        int           cyc;
    } exp_strobe_t;
    exp_strobe_t sq[$];
    int          dq[$];

    fabric_bitstream_loader #(
        .NUM_ROWS(4), .NUM_COLUMNS(2), .FRAMES_PER_COL(4), .SYNC_WORD(SYNC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .bitstream_data_i(data), .bitstream_valid_i(valid),
        .frame_data_o(frame_data), .frame_strobe_o(strobe),
        .config_busy_o(busy), .config_done_o(done), .error_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (strobe != 8'd0) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected actual=%h cyc=%0d required=none", strobe, cyc);
            end else begin
                exp_strobe_t e;
                e = sq.pop_front();
                if (strobe !== e.strobe || frame_data !== e.frame || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe actual=%h/%h@%0d required=%h/%h@%0d",
                             strobe, frame_data, cyc, e.strobe, e.frame, e.cyc);
                end
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected actual=1 cyc=%0d required=none", cyc);
            end else begin
                int ec;
                ec = dq.pop_front();
                if (cyc != ec) begin
                    errors++;
                    $display("FAIL done_cycle actual=%0d required=%0d", cyc, ec);
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_word();
        msum = '0;
        send(SYNC);
    endtask

    task automatic frame(input logic [31:0] hdr, d0, d1, d2, d3, input int bi);
        exp_strobe_t e;
        send(hdr);
        send(d0); send(d1); send(d2);
        if (bi >= 0) begin
            e.strobe = 8'd1 << bi;
            e.frame  = {d0, d1, d2, d3};
            e.cyc    = cyc + 2;
            sq.push_back(e);
        end
        send(d3);
        msum = msum + d0 + d1 + d2 + d3;
        check("frame_data", frame_data, {d0, d1, d2, d3});
    endtask

    task automatic desync();
`ifdef FABRIC_LOADER_CHECKSUM_EN
        send(32'hD000_0000);
        dq.push_back(cyc + 1);
        send(msum);
`else
        dq.push_back(cyc + 1);
        send(32'hD000_0000);
`endif
    endtask

    initial begin
        idle(3);
        check("rst_strobe", 128'(strobe), 128'd0);
        check("rst_frame", frame_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_error", 128'(err), 128'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: words without sync are ignored
        send(32'h1234_5678);
        send(32'h1000_0000);
        idle(3);
        check("t1_busy", 128'(busy), 128'd0);
        check("t1_error", 128'(err), 128'd0);

        // 2: single frame, column 1 frame 2 -> bit 6
        sync_word();
        check("t2_busy", 128'(busy), 128'd1);
        frame(32'h1001_0002, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 6);
        idle(3);

        // 3: back-to-back frames then desync
        frame(32'h1000_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004, 0);
        frame(32'h1001_0003, 32'hB0B0_0001, 32'hB0B0_0002, 32'hB0B0_0003, 32'hB0B0_0004, 7);
        desync();
        idle(3);
        check("t3_busy", 128'(busy), 128'd0);
        check("t3_error", 128'(err), 128'd0);

        // 4: out-of-range column, then valid frame, sticky error, sync clears
        sync_word();
        frame(32'h1002_0000, 32'hC0C0_0001, 32'hC0C0_0002, 32'hC0C0_0003, 32'hC0C0_0004, -1);
        check("t4_error", 128'(err), 128'd1);
        check("t4_busy", 128'(busy), 128'd1);
        frame(32'h1000_0001, 32'hD0D0_0001, 32'hD0D0_0002, 32'hD0D0_0003, 32'hD0D0_0004, 1);
        desync();
        idle(3);
        check("t4_error_sticky", 128'(err), 128'd1);
        sync_word();
        check("t4_error_clear", 128'(err), 128'd0);

        // bad opcode inside a session
        send(32'h3000_0000);
        check("bad_op_error", 128'(err), 128'd1);
        check("bad_op_busy", 128'(busy), 128'd0);
        idle(2);

        // 5: reset mid-frame
        sync_word();
        send(32'h1001_0001);
        send(32'hE0E0_0001);
        send(32'hE0E0_0002);
        rst_n = 1'b0;
        #1;
        check("t5_frame", frame_data, 128'd0);
        check("t5_strobe", 128'(strobe), 128'd0);
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_error", 128'(err), 128'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(32'h1001_0001);
        send(32'hF0F0_0001); send(32'hF0F0_0002); send(32'hF0F0_0003); send(32'hF0F0_0004);
        idle(3);
        check("t5_ignored_busy", 128'(busy), 128'd0);
        check("t5_ignored_frame", frame_data, 128'd0);

`ifdef FABRIC_LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        sync_word();
        frame(32'h1000_0000, 32'd1, 32'd2, 32'd3, 32'd4, 0);
        send(32'hD000_0000);
        check("t6_busy_check", 128'(busy), 128'd1);
        dq.push_back(cyc + 1);
        send(32'h0000_000A);
        idle(2);
        check("t6_good_error", 128'(err), 128'd0);
        sync_word();
        frame(32'h1000_0000, 32'd1, 32'd2, 32'd3, 32'd4, 0);
        send(32'hD000_0000);
        send(32'h0000_000B);
        idle(3);
        check("t6_bad_error", 128'(err), 128'd1);
        check("t6_bad_busy", 128'(busy), 128'd0);
`endif

        idle(4);
        check("strobe_queue_empty", 128'(sq.size()), 128'd0);
        check("done_queue_empty", 128'(dq.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fabric_bitstream_loader.md
Name: fabric_bitstream_loader

Overview:
- Consumes the 32-bit word stream produced by the fabric SPI receiver.
- Parses a sync / header / data protocol and assembles one frame of configuration data.
- Writes each frame into the fabric by driving the frame data bus and pulsing exactly one frame strobe bit.
- Sits between the SPI receiver and the fabric's frame-data/frame-strobe configuration inputs.

Parameters:
- NUM_ROWS, 16: 32-bit data words per frame, one per fabric row; frame_data_o width = NUM_ROWS*32.
- NUM_COLUMNS, 16: number of fabric columns (strobe groups).
- FRAMES_PER_COL, 20: frames per column (strobe bits per group).
- SYNC_WORD, 32'hFAB0_FAB1: word that starts a configuration session.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- bitstream_data_i  input  32  word from SPI receiver
- bitstream_valid_i  input  1  one-cycle qualifier per word; may be asserted every cycle; no backpressure
- frame_data_o  output  NUM_ROWS*32  assembled frame data
- frame_strobe_o  output  NUM_COLUMNS*FRAMES_PER_COL  one-hot write strobe
- config_busy_o  output  1  high while a session is open (sync seen, no desync yet)
- config_done_o  output  1  one-cycle pulse on successful session end
- error_o  output  1  sticky protocol error flag

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - All outputs 0; frame_data_o = 0; FSM = IDLE; internal counters = 0.
  - Reset asserted mid-frame aborts the frame; no strobe is issued.
- A word is consumed only in a cycle with bitstream_valid_i = 1. The block never stalls, and no valid word may be dropped in any state.
- IDLE:
  - Non-sync words are ignored.
  - Word == SYNC_WORD -> HEADER; error_o cleared; config_busy_o = 1 from the next cycle.
- HEADER, word decode:
  - [31:28] opcode, [23:16] column, [4:0] frame index.
  - Opcode 4'h1 (frame write) -> DATA; row counter = 0; column and frame captured.
  - Opcode 4'hD (desync) -> IDLE; config_done_o pulses the next cycle; config_busy_o drops the same cycle.
  - Any other opcode -> error_o = 1, IDLE, config_busy_o = 0, no done pulse.
- DATA:
  - Each word is shifted into a row buffer; the first word lands in bits [NUM_ROWS*32-1 -: 32] and the last word in [31:0].
  - Row counter width is clog2(NUM_ROWS), minimum 1.
  - On word NUM_ROWS: frame_data_o is updated with the complete frame in the cycle after that word, and FSM -> HEADER.
  - frame_strobe_o bit (column*FRAMES_PER_COL + frame) is high for exactly one cycle, 2 cycles after the last data word's valid cycle.
  - frame_data_o already holds the new frame during the strobe cycle and stays stable until the next frame completes.
- A header word arriving in the strobe cycle (back-to-back stream) is accepted normally.
- Out-of-range target (column >= NUM_COLUMNS or frame >= FRAMES_PER_COL):
  - error_o = 1.
  - The NUM_ROWS data words are still consumed and frame_data_o is still updated.
  - No strobe is issued.
  - The session continues in HEADER.
- SYNC_WORD received inside a session is treated as an ordinary word: a header decode by opcode, or data in DATA.
- frame_strobe_o never has more than one bit set.
- error_o stays high until reset or the next sync word seen in IDLE.

Optional Feature:
- Macro: FABRIC_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit wrapping sum of all DATA words is accumulated, cleared on sync.
  - After a desync header, FSM enters CHECK and waits for one more word.
  - If that word equals the sum: config_done_o pulses the next cycle.
  - Otherwise: error_o = 1 and no done pulse.
  - In both cases FSM -> IDLE, and config_busy_o stays high until the checksum word is consumed.
- Without the macro: no accumulator and no CHECK state; desync ends the session immediately as described above.

Test Plan:
- Bench parameters: NUM_ROWS=4, NUM_COLUMNS=2, FRAMES_PER_COL=4.
- 1. Reset, then words 32'h12345678 and 32'h1000_0000 without sync -> no strobe, busy=0, error=0.
- 2. Sync; header 32'h1001_0002; data 11111111, 22222222, 33333333, 44444444 -> frame_data_o = 32'h11111111_22222222_33333333_44444444, then strobe bit 6 high for 1 cycle, exactly 2 cycles after the last valid.
- 3. Back-to-back valid every cycle: two frames (col0/frame0, col1/frame3), then header 32'hD000_0000 -> strobes at bits 0 and 7, done pulses once, busy falls.
- 4. Header 32'h1002_0000 (column 2, out of range) plus 4 data words -> error_o = 1, no strobe; a following valid frame still strobes; a new sync after desync clears error.
- 5. Reset asserted after the 2nd data word -> all outputs 0 immediately; after release, words are ignored until sync.
- 6. With FABRIC_LOADER_CHECKSUM_EN defined: one frame with data 1,2,3,4, desync, then checksum 32'h0000000A -> done pulse. Repeat with checksum 32'h0000000B -> error_o = 1 and no done pulse.
